// File: rtl/bus_timer_intc.sv
// Memory-mapped prescaled down-counter timer with a small interrupt controller.
// Define TIMER_EXT_IRQ_EN to include the external-interrupt synchronizers, EPEND and EMASK.
module bus_timer_intc #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        hit_o,
    input  logic [4:0]  ext_irq_i,
    output logic [5:0]  int_o
);
    localparam logic [2:0] A_CTRL  = 3'd0;
    localparam logic [2:0] A_PRESC = 3'd1;
    localparam logic [2:0] A_LOAD  = 3'd2;
    localparam logic [2:0] A_COUNT = 3'd3;
    localparam logic [2:0] A_TSTAT = 3'd4;
    localparam logic [2:0] A_EPEND = 3'd5;
    localparam logic [2:0] A_EMASK = 3'd6;

    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d;
    logic [31:0]           load_q, load_d;
    logic [31:0]           count_q, count_d;
    logic                  tpend_q, tpend_d;
    logic                  wr, tick, tpend_set, tpend_clr;
    logic [2:0]            sel;
    logic [31:0]           rdata;

`ifdef TIMER_EXT_IRQ_EN
    logic [4:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [4:0] epend_q, epend_d, emask_q, emask_d, epend_clr, irq_edge;
    logic [1:0] arm_q, arm_d;
    logic       unused_bits;
    assign unused_bits = ^addr_i[1:0];
`else
    logic       unused_bits;
    assign unused_bits = ^{addr_i[1:0], ext_irq_i};
`endif

    assign hit_o = ce_i && (addr_i[31:5] == BASE_ADDR[31:5]);

    always_comb begin
        wr         = hit_o & we_i;
        sel        = addr_i[4:2];
        tick       = ctrl_q[0] && (psc_q == prescale_q);
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        load_d     = load_q;
        count_d    = count_q;
        tpend_set  = 1'b0;
        tpend_clr  = 1'b0;

        // Prescaler rests at 0 while disabled, so enabling always starts a full period.
        if (!ctrl_q[0] || tick)
            psc_d = '0;
        else
            psc_d = psc_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};

        if (tick) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                tpend_set = 1'b1;
                if (ctrl_q[1]) count_d   = load_q;
                else           ctrl_d[0] = 1'b0;
            end
        end

`ifdef TIMER_EXT_IRQ_EN
        sync1_d   = ext_irq_i;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        arm_d     = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;
        // Suppress edges until the history holds real samples: a line high at release is not an edge.
        irq_edge  = (arm_q == 2'd3) ? (sync2_q & ~prev_q) : 5'd0;
        emask_d   = emask_q;
        epend_clr = 5'd0;
`endif

        // Bus writes are applied last so they override the tick-driven updates.
        if (wr) begin
            case (sel)
                A_CTRL:  ctrl_d     = data_i[2:0];
                A_PRESC: prescale_d = data_i[PRESCALE_W-1:0];
                A_LOAD:  load_d     = data_i;
                A_COUNT: count_d    = data_i;
                A_TSTAT: tpend_clr  = data_i[0];
`ifdef TIMER_EXT_IRQ_EN
                A_EPEND: epend_clr  = data_i[4:0];
                A_EMASK: emask_d    = data_i[4:0];
`endif
                default: ;
            endcase
        end

        tpend_d = tpend_set | (tpend_q & ~tpend_clr);
`ifdef TIMER_EXT_IRQ_EN
        epend_d = irq_edge | (epend_q & ~epend_clr);
`endif

        rdata = 32'd0;
        case (sel)
            A_CTRL:  rdata = {29'd0, ctrl_q};
            A_PRESC: rdata = 32'(prescale_q);
            A_LOAD:  rdata = load_q;
            A_COUNT: rdata = count_q;
            A_TSTAT: rdata = {31'd0, tpend_q};
`ifdef TIMER_EXT_IRQ_EN
            A_EPEND: rdata = {27'd0, epend_q};
            A_EMASK: rdata = {27'd0, emask_q};
`endif
            default: rdata = 32'd0;
        endcase
    end

    assign data_o = (hit_o && !we_i) ? rdata : 32'd0;

`ifdef TIMER_EXT_IRQ_EN
    assign int_o = {tpend_q & ctrl_q[2], epend_q & emask_q};
`else
    assign int_o = {tpend_q & ctrl_q[2], 5'd0};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            psc_q      <= '0;
            load_q     <= '0;
            count_q    <= '0;
            tpend_q    <= 1'b0;
`ifdef TIMER_EXT_IRQ_EN
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            arm_q      <= '0;
            epend_q    <= '0;
            emask_q    <= '0;
`endif
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            psc_q      <= psc_d;
            load_q     <= load_d;
            count_q    <= count_d;
            tpend_q    <= tpend_d;
`ifdef TIMER_EXT_IRQ_EN
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            arm_q      <= arm_d;
            epend_q    <= epend_d;
            emask_q    <= emask_d;
`endif
        end
    end
endmodule

// File: doc/bus_timer_intc.md
BUS_TIMER_INTC -- requirements
Module: bus_timer_intc

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1000_0000, 32-byte-aligned base of the register window.
REQ-002 Parameter PRESCALE_W, default 16, width of the prescaler register and counter.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ce_i  input  1  data-bus chip enable, driven by the CPU data-memory port.
REQ-006 we_i  input  1  write enable, qualified by ce_i.
REQ-007 addr_i  input  32  byte address; addr_i[4:2] selects the register.
REQ-008 data_i  input  32  write data.
REQ-009 data_o  output  32  read data, combinational from registers.
REQ-010 hit_o  output  1  high when ce_i=1 and addr_i[31:5]==BASE_ADDR[31:5].
REQ-011 ext_irq_i  input  5  asynchronous external interrupt lines.
REQ-012 int_o  output  6  interrupt vector to the CP0 int_i input.

Function
REQ-013 Register map (word offsets):
- 0x00 CTRL: [0] EN, [1] AUTO, [2] TIE.
- 0x04 PRESCALE.
- 0x08 LOAD.
- 0x0C COUNT.
- 0x10 TSTAT: [0] TPEND, write-1-to-clear.
- 0x14 EPEND: [4:0], write-1-to-clear.
- 0x18 EMASK: [4:0].
REQ-014 A write occurs when hit_o=1 and we_i=1, and takes effect at the next clock edge.
REQ-015 Offset 0x1C and unused bits read 0; writes to them are ignored.
REQ-016 data_o is 0 when hit_o=0 or we_i=1.
REQ-017 When EN=1, the prescaler counts 0..PRESCALE and emits a one-cycle tick on the wrap, giving one tick every PRESCALE+1 clocks.
REQ-018 When EN=0, the prescaler is held at 0.
REQ-019 On a tick with COUNT!=0, COUNT decrements by 1.
REQ-020 On a tick with COUNT==0: TPEND is set; if AUTO=1, COUNT<=LOAD; if AUTO=0, EN<=0 and COUNT stays at 0 (one-shot).
REQ-021 A bus write to COUNT in the same cycle as a tick takes priority over the tick update.
REQ-022 A bus write to CTRL in the same cycle as a one-shot expiry takes priority over the EN<=0 update.
REQ-023 A write to CTRL that changes EN from 0 to 1 clears the prescaler, so the first tick arrives exactly PRESCALE+1 clocks later.
REQ-024 Each ext_irq_i bit passes through a 2-flop synchronizer and a rising-edge detector; a detected edge sets the matching EPEND bit.
REQ-025 A hardware set and a W1C of the same pending bit in the same cycle: the set wins. This applies to TPEND and EPEND.
REQ-026 int_o[5] = TPEND & TIE; int_o[4:0] = EPEND & EMASK. int_o is combinational from registers.
REQ-027 Arithmetic is unsigned. COUNT is 32 bits and never wraps below 0.

Reset
REQ-028 While rst=1, all registers, the prescaler, the synchronizers and the edge-detect history are 0, so int_o=0 and data_o=0.
REQ-029 Asserting rst mid-count aborts the count immediately with no pending side effects.
REQ-030 After deassertion, the first edge of a line held high raises EPEND only once the synchronizer has seen a 0->1 transition; a level that is already high at reset release is not an edge.

Configuration
REQ-031 The macro TIMER_EXT_IRQ_EN controls the external-interrupt logic.
- Defined: the synchronizers, EPEND and EMASK are present as specified above.
- Undefined: ext_irq_i is ignored, offsets 0x14 and 0x18 read 0 and ignore writes, int_o[4:0]=0, and the logic is removed.

Verification
REQ-032 PRESCALE=3, LOAD=2, COUNT=2, CTRL=3 -> TPEND sets 12 clocks after the CTRL write; COUNT reloads to 2; int_o[5] stays 0 (TIE=0).
REQ-033 One-shot: PRESCALE=0, COUNT=1, CTRL=5 -> after 2 clocks TPEND=1, int_o=6'b100000, EN reads 0, COUNT=0 and holds.
REQ-034 Write 1 to TSTAT in the same cycle that TPEND is set -> TPEND remains 1.
REQ-035 (TIMER_EXT_IRQ_EN) EMASK=5'b00100, pulse ext_irq_i[2] high for 1 clock -> EPEND=5'b00100 within 3 clocks and int_o[2]=1; W1C 0x14 with 4 -> int_o=0.
REQ-036 Read address BASE_ADDR+0x20 -> hit_o=0, data_o=0. Read BASE_ADDR+0x1C -> hit_o=1, data_o=0.
REQ-037 Assert rst while COUNT=100 with EN=1 -> COUNT, CTRL and int_o read 0 immediately with no clock edge; after release, COUNT stays 0.
